fast_field_encoder: RTL and testbench

Transmit-side FAST field encoder for the HFT/FAST path, the counterpart of the receive-side decoder and field FIFO. It accepts one unsigned integer field per cycle tagged with message ID and field index, stop-bit encodes it into 1..10 bytes, and packs the bytes MSB-first into 64-bit beats. Each message closes with a flushed, byte-counted beat carrying `out_last`.

---
 rtl/fast_enc_pkg.sv | 16 +
 rtl/fast_stopbit_enc.sv | 53 +++++
 rtl/fast_field_encoder.sv | 154 +++++++++++++++
 tb/tb_fast_field_encoder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_enc_pkg.sv
// rtl/fast_enc_pkg.sv - shared types and constants for the FAST stop-bit field encoder
package fast_enc_pkg;

    localparam int MAX_FIELD_BYTES = 10;
    localparam int COUNT_W         = $clog2(MAX_FIELD_BYTES + 1);
    localparam logic [7:0] STOP_BIT = 8'h80;

    typedef logic [7:0] byte_t;

    // bytes[0] is the first byte on the wire
    typedef struct packed {
        byte_t [MAX_FIELD_BYTES-1:0] bytes;
        logic  [COUNT_W-1:0]         count;
    } enc_field_t;

endpackage

// File: rtl/fast_stopbit_enc.sv
// rtl/fast_stopbit_enc.sv - combinational FAST stop-bit encoder, 1..10 bytes left-justified
// FAST_ENC_NULLABLE_EN selects nullable unsigned encoding (null -> 0x80, else value+1).
module fast_stopbit_enc
    import fast_enc_pkg::*;
(
    input  logic [63:0] value_i,
    input  logic        null_i,
    output enc_field_t  enc_o
);

    localparam int PAD_W = 7 * MAX_FIELD_BYTES;

    logic [PAD_W-1:0]   padded;
    logic [6:0]         grp [MAX_FIELD_BYTES];
    logic [COUNT_W-1:0] n;

`ifdef FAST_ENC_NULLABLE_EN
    logic [64:0] inc;
    assign inc    = {1'b0, value_i} + 65'd1;
    assign padded = {{(PAD_W-65){1'b0}}, inc};
`else
    logic unused_null;
    assign unused_null = null_i;
    assign padded      = {{(PAD_W-64){1'b0}}, value_i};
`endif

    always_comb begin
        n = COUNT_W'(1);
        for (int k = 0; k < MAX_FIELD_BYTES; k++) begin
            grp[k] = padded[7*k +: 7];
            if (grp[k] != 7'd0) n = COUNT_W'(k + 1);
        end

        // Group n-1 goes out first; only the final byte carries the stop bit
        enc_o       = '0;
        enc_o.count = n;
        for (int i = 0; i < MAX_FIELD_BYTES; i++) begin
            for (int k = 0; k < MAX_FIELD_BYTES; k++) begin
                if (i < int'(n) && k == int'(n) - 1 - i)
                    enc_o.bytes[i] = {(i == int'(n) - 1), grp[k]};
            end
        end

`ifdef FAST_ENC_NULLABLE_EN
        if (null_i) begin
            enc_o          = '0;
            enc_o.bytes[0] = STOP_BIT;
            enc_o.count    = COUNT_W'(1);
        end
`endif
    end

endmodule

// File: rtl/fast_field_encoder.sv
// rtl/fast_field_encoder.sv - FAST field encoder: byte accumulator and beat packer
// Optional nullable encoding lives in fast_stopbit_enc under FAST_ENC_NULLABLE_EN.
module fast_field_encoder
    import fast_enc_pkg::*;
#(
    parameter int beat_width       = 64,
    parameter int max_message_size = 10,
    parameter int messageID_size   = 21
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [63:0]                           in_value,
    input  logic                                  in_null,
    input  logic [messageID_size-1:0]             in_msg_id,
    input  logic [$clog2(max_message_size)-1:0]   in_field_idx,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [beat_width-1:0]                 out_data,
    output logic [$clog2(beat_width/8):0]         out_nbytes,
    output logic                                  out_last,
    output logic [messageID_size-1:0]             out_msg_id,
    output logic                                  out_idx_err
);

    localparam int BPB       = beat_width / 8;
    localparam int ACC_BYTES = BPB + MAX_FIELD_BYTES - 1;
    localparam int FILL_W    = $clog2(ACC_BYTES + 1);
    localparam int IDX_W     = $clog2(max_message_size);
    localparam int NB_W      = $clog2(BPB) + 1;

    enc_field_t enc;

    fast_stopbit_enc u_enc (
        .value_i (in_value),
        .null_i  (in_null),
        .enc_o   (enc)
    );

    byte_t                     acc_q [ACC_BYTES];
    byte_t                     acc_d [ACC_BYTES];
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic                      flush_q, flush_d;
    logic                      first_q, first_d;
    logic [messageID_size-1:0] msg_id_q, msg_id_d;
    logic [IDX_W-1:0]          exp_idx_q, exp_idx_d;
    logic                      out_valid_q, out_valid_d;
    logic [beat_width-1:0]     out_data_q, out_data_d;
    logic [NB_W-1:0]           out_nbytes_q, out_nbytes_d;
    logic                      out_last_q, out_last_d;
    logic [messageID_size-1:0] out_msg_id_q, out_msg_id_d;
    logic                      err_q, err_d;

    logic accept, full_beat, load;

    assign in_ready  = (fill_q < FILL_W'(BPB)) && !flush_q;
    assign accept    = in_valid && in_ready;
    assign full_beat = fill_q >= FILL_W'(BPB);
    assign load      = (!out_valid_q || out_ready) && (full_beat || (fill_q != '0 && flush_q));

    always_comb begin
        acc_d        = acc_q;
        fill_d       = fill_q;
        flush_d      = flush_q;
        first_d      = first_q;
        msg_id_d     = msg_id_q;
        exp_idx_d    = exp_idx_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_nbytes_d = out_nbytes_q;
        out_last_d   = out_last_q;
        out_msg_id_d = out_msg_id_q;
        err_d        = err_q;

        // in_ready excludes fill >= BPB and flush, so load and accept never coincide
        if (load) begin
            out_valid_d  = 1'b1;
            out_msg_id_d = msg_id_q;
            for (int i = 0; i < BPB; i++)
                out_data_d[beat_width-1-8*i -: 8] =
                    (full_beat || FILL_W'(i) < fill_q) ? acc_q[i] : 8'h00;
            if (full_beat) begin
                out_nbytes_d = NB_W'(BPB);
                out_last_d  = flush_q && (fill_q == FILL_W'(BPB));
                for (int p = 0; p < ACC_BYTES - BPB; p++)
                    acc_d[p] = acc_q[p + BPB];
                for (int p = ACC_BYTES - BPB; p < ACC_BYTES; p++)
                    acc_d[p] = 8'h00;
                fill_d = fill_q - FILL_W'(BPB);
                if (fill_q == FILL_W'(BPB)) flush_d = 1'b0;
            end else begin
                out_nbytes_d = NB_W'(fill_q);
                out_last_d   = 1'b1;
                fill_d       = '0;
                flush_d      = 1'b0;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            for (int p = 0; p < ACC_BYTES; p++)
                for (int j = 0; j < MAX_FIELD_BYTES; j++)
                    if (j < int'(enc.count) && p == int'(fill_q) + j)
                        acc_d[p] = enc.bytes[j];
            fill_d  = fill_q + FILL_W'(enc.count);
            flush_d = in_last;
            if (first_q) msg_id_d = in_msg_id;
            first_d = in_last;
            if (in_field_idx != exp_idx_q) err_d = 1'b1;
            exp_idx_d = in_last ? '0 : exp_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < ACC_BYTES; p++) acc_q[p] <= 8'h00;
            fill_q       <= '0;
            flush_q      <= 1'b0;
            first_q      <= 1'b1;
            msg_id_q     <= '0;
            exp_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_nbytes_q <= '0;
            out_last_q   <= 1'b0;
            out_msg_id_q <= '0;
            err_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_q      <= flush_d;
            first_q      <= first_d;
            msg_id_q     <= msg_id_d;
            exp_idx_q    <= exp_idx_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_nbytes_q <= out_nbytes_d;
            out_last_q   <= out_last_d;
            out_msg_id_q <= out_msg_id_d;
            err_q        <= err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_nbytes  = out_nbytes_q;
    assign out_last    = out_last_q;
    assign out_msg_id  = out_msg_id_q;
    assign out_idx_err = err_q;

endmodule

// File: tb/tb_fast_field_encoder.sv
// tb/tb_fast_field_encoder.sv - self-checking bench for fast_field_encoder
module tb_fast_field_encoder;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [63:0] data;
        logic [3:0]  nb;
        logic        last;
        logic [20:0] id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_null, in_last;
    logic [63:0] in_value;
    logic [20:0] in_msg_id;
    logic [3:0]  in_field_idx;
    logic        out_valid, out_ready, out_last, out_idx_err;
    logic [63:0] out_data;
    logic [3:0]  out_nbytes;
    logic [20:0] out_msg_id;

    int checks = 0;
    int errors = 0;
    logic rand_rdy = 1'b0;

    beat_t       exp_q[$];
    logic [7:0]  pend[$];
    int          fields = 0;
    logic [20:0] cur_id = '0;
    logic        err_m = 1'b0;

    fast_field_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .in_null      (in_null),
        .in_msg_id    (in_msg_id),
        .in_field_idx (in_field_idx),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_nbytes   (out_nbytes),
        .out_last     (out_last),
        .out_msg_id   (out_msg_id),
        .out_idx_err  (out_idx_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Stop-bit encoding straight from the arithmetic definition
    function automatic bq_t encode(input logic [69:0] x);
        bq_t q;
        int  n;
        logic [7:0] b;
        n = 1;
        while (n < 10 && (x >> (7 * n)) != 70'd0) n++;
        for (int i = 0; i < n; i++) begin
            b = {1'b0, 7'((x >> (7 * (n - 1 - i))) & 70'h7F)};
            if (i == n - 1) b[7] = 1'b1;
            q.push_back(b);
        end
        return q;
    endfunction

    function automatic beat_t take_beat(input int nb, input logic last, input logic [20:0] id);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < nb; i++) b.data[63 - 8*i -: 8] = pend.pop_front();
        b.nb   = 4'(nb);
        b.last = last;
        b.id   = id;
        return b;
    endfunction

    // Reference model and compare process, evaluated at every falling edge
    initial begin
        logic        have_prev;
        logic [63:0] p_data;
        logic [3:0]  p_nb;
        logic        p_last;
        logic [20:0] p_id;
        beat_t       b;
        bq_t         eb;
        have_prev = 1'b0;
        p_data = '0; p_nb = '0; p_last = 1'b0; p_id = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pend.delete();
                fields    = 0;
                err_m     = 1'b0;
                have_prev = 1'b0;
            end else begin
                chk("idx_err", out_idx_err, err_m);
                if (have_prev) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_data", out_data, p_data);
                    chk("hold_nbytes", out_nbytes, p_nb);
                    chk("hold_last", out_last, p_last);
                    chk("hold_id", out_msg_id, p_id);
                end
                have_prev = out_valid && !out_ready;
                p_data = out_data; p_nb = out_nbytes; p_last = out_last; p_id = out_msg_id;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h with no beat expected", out_data);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", out_data, b.data);
                        chk("beat_nbytes", out_nbytes, b.nb);
                        chk("beat_last", out_last, b.last);
                        chk("beat_id", out_msg_id, b.id);
                    end
                end
                if (in_valid && in_ready) begin
`ifdef FAST_ENC_NULLABLE_EN
                    if (in_null) begin
                        eb = {};
                        eb.push_back(8'h80);
                    end else begin
                        eb = encode(70'(in_value) + 70'd1);
                    end
`else
                    eb = encode(70'(in_value));
`endif
                    if (fields == 0) cur_id = in_msg_id;
                    if (int'(in_field_idx) != fields) err_m = 1'b1;
                    fields++;
                    foreach (eb[i]) pend.push_back(eb[i]);
                    while (pend.size() >= 8)
                        exp_q.push_back(take_beat(8, in_last && pend.size() == 8, cur_id));
                    if (in_last && pend.size() > 0)
                        exp_q.push_back(take_beat(pend.size(), 1'b1, cur_id));
                    if (in_last) fields = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [63:0] v, input logic [20:0] id, input logic [3:0] idx,
                        input logic last);
        int w;
        w = 0;
        in_valid = 1'b1; in_value = v; in_msg_id = id; in_field_idx = idx; in_last = last;
        in_null  = 1'b0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) fail_now("send");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) fail_now(name);
    endtask

    task automatic single(input logic [63:0] v, input logic [20:0] id, input logic [63:0] data,
                          input logic [3:0] nb);
        send(v, id, 4'd0, 1'b1);
        @(negedge clk);
        chk("latency_pre", out_valid, 1'b0);
        @(negedge clk);
        chk("latency_post", out_valid, 1'b1);
        chk("single_data", out_data, data);
        chk("single_nbytes", out_nbytes, nb);
        chk("single_last", out_last, 1'b1);
        chk("single_id", out_msg_id, id);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t q;
        logic [3:0] idx;
        int w;
        rst = 1'b1; in_valid = 1'b0; in_value = '0; in_null = 1'b0; in_msg_id = '0;
        in_field_idx = '0; in_last = 1'b0; out_ready = 1'b1;

        q = encode(70'd0);
        chk("pin_enc0", {q.size(), q[0]}, {32'd1, 8'h80});
        q = encode(70'h7F);
        chk("pin_enc7f", {q.size(), q[0]}, {32'd1, 8'hFF});
        q = encode(70'h80);
        chk("pin_enc80", {q.size(), q[0], q[1]}, {32'd2, 8'h01, 8'h80});
        q = encode(70'hFFFF_FFFF_FFFF_FFFF);
        chk("pin_encmax", {q.size(), q[0], q[1], q[8], q[9]}, {32'd10, 8'h01, 8'h7F, 8'h7F, 8'hFF});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_nbytes", out_nbytes, 4'h0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_id", out_msg_id, 21'h0);
        chk("rst_err", out_idx_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        single(64'h0, 21'd5, 64'h8000_0000_0000_0000, 4'd1);
        single(64'h7F, 21'd6, 64'hFF00_0000_0000_0000, 4'd1);
        single(64'h80, 21'd7, 64'h0180_0000_0000_0000, 4'd2);

        send(64'hFFFF_FFFF_FFFF_FFFF, 21'd8, 4'd0, 1'b1);
        wait_valid("max_beat1");
        chk("max_b1_data", out_data, 64'h017F_7F7F_7F7F_7F7F);
        chk("max_b1_nbytes", out_nbytes, 4'd8);
        chk("max_b1_last", out_last, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("max_b2_valid", out_valid, 1'b1);
        chk("max_b2_data", out_data, 64'h7FFF_0000_0000_0000);
        chk("max_b2_nbytes", out_nbytes, 4'd2);
        chk("max_b2_last", out_last, 1'b1);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) send(64'd1, 21'(100 + k), 4'(k), k == 8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, 64'h8181_8181_8181_8181);
            chk("stall_last", out_last, 1'b0);
            chk("stall_id", out_msg_id, 21'd100);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("nine_b2_data", out_data, 64'h8100_0000_0000_0000);
        chk("nine_b2_nbytes", out_nbytes, 4'd1);
        chk("nine_b2_last", out_last, 1'b1);
        chk("nine_err", out_idx_err, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("nine_once", out_valid, 1'b0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) send(64'd1, 21'd7, 4'(k), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("mrst_no_beat", out_valid, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        single(64'd3, 21'd9, 64'h8300_0000_0000_0000, 4'd1);
        chk("mrst_err", out_idx_err, 1'b0);

        rand_rdy = 1'b1;
        idx = 4'd0;
        for (int n = 0; n < 400; n++) begin
            logic last;
            last = ($urandom_range(0, 3) == 0) || (idx == 4'd9);
            send({$urandom, $urandom} >> $urandom_range(0, 63), 21'($urandom), idx, last);
            idx = last ? 4'd0 : idx + 4'd1;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        if (idx != 4'd0) send(64'd42, 21'd1, idx, 1'b1);
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (exp_q.size() != 0 || out_valid) fail_now("drain");
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        send(64'd5, 21'd2, 4'd1, 1'b1);
        wait_valid("err_beat");
        chk("err_set", out_idx_err, 1'b1);
        chk("err_beat_data", out_data, 64'h8500_0000_0000_0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", out_idx_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
